// File: rtl/audio_uart_pkg.sv
// Shared definitions for the audio UART: FSM state encoding, frame width and line levels.
package audio_uart_pkg;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_e;

endpackage

// File: rtl/audio_uart_rx_sync.sv
// Two-flop synchronizer for the serial line; flops come out of reset at the idle level
// so a freshly reset receiver never sees a phantom start bit from the synchronizer itself.
module audio_uart_rx_sync
  import audio_uart_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) sync_q <= {2{IDLE_LEVEL}};
    else       sync_q <= {sync_q[0], i_d};
  end

  assign o_q = sync_q[1];

endmodule

// File: rtl/audio_uart_rx.sv
// 8N1 serial receiver with valid/ready byte output, framing and overrun pulses.
// Define AUDIO_UART_RX_SYNC_EN to pass i_serial through a two-flop synchronizer (+2 cycles latency).
module audio_uart_rx
  import audio_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_serial,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = (HALF > 0) ? CW'(HALF - 1) : '0;

  logic s;

`ifdef AUDIO_UART_RX_SYNC_EN
  audio_uart_rx_sync u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_serial),
    .o_q   (s)
  );
`else
  assign s = i_serial;
`endif

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 done;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    done    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      WAIT_IDLE: if (s == IDLE_LEVEL) state_d = IDLE;
      IDLE: begin
        if (s == START_LEVEL) begin
          // Short bit periods have no room for a mid-start check; go straight to data.
          if (HALF == 0) begin
            state_d = DATA;
            cnt_d   = CNT_BIT;
            idx_d   = 3'd0;
          end else begin
            state_d = START;
            cnt_d   = CNT_HALF;
          end
        end
      end
      START: begin
        if (cnt_q != '0)              cnt_d = cnt_q - CW'(1);
        else if (s == START_LEVEL) begin
          state_d = DATA;
          cnt_d   = CNT_BIT;
          idx_d   = 3'd0;
        end else                      state_d = IDLE;
      end
      DATA: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else begin
          shreg_d[idx_q] = s;
          cnt_d          = CNT_BIT;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q != '0)            cnt_d = cnt_q - CW'(1);
        else if (s == IDLE_LEVEL) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = WAIT_IDLE;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    // A consume and a new byte in the same cycle hand over without an overrun.
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (done) begin
      if (!valid_q || i_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d   = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shreg_q <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_audio_uart_rx.sv
// Directed bench for audio_uart_rx: one instance at 1 clock/bit, one at 16 clocks/bit.
module tb_audio_uart_rx;

`ifdef AUDIO_UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser_a = 1'b1, ser_b = 1'b1;
  logic       rdy_a = 1'b1, rdy_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       val_a, val_b, fe_a, fe_b, ov_a, ov_b;

  always #5 clk = ~clk;

  audio_uart_rx #(.CLKS_PER_BIT(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_serial(ser_a), .o_data(data_a), .o_valid(val_a),
    .i_ready(rdy_a), .o_frame_err(fe_a), .o_overrun(ov_a));

  audio_uart_rx #(.CLKS_PER_BIT(16)) u_b (
    .i_clk(clk), .i_rst(rst), .i_serial(ser_b), .o_data(data_b), .o_valid(val_b),
    .i_ready(rdy_b), .o_frame_err(fe_b), .o_overrun(ov_b));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fe_cnt_a = 0, ov_cnt_a = 0, fe_cnt_b = 0, ov_cnt_b = 0;
  logic [7:0] qa_d[$], qb_d[$];
  int         qa_c[$], qb_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every accepted byte with its cycle and count flag pulses.
  always @(negedge clk) begin
    if (val_a && rdy_a) begin qa_d.push_back(data_a); qa_c.push_back(cyc); end
    if (val_b && rdy_b) begin qb_d.push_back(data_b); qb_c.push_back(cyc); end
    if (fe_a) fe_cnt_a <= fe_cnt_a + 1;
    if (ov_a) ov_cnt_a <= ov_cnt_a + 1;
    if (fe_b) fe_cnt_b <= fe_cnt_b + 1;
    if (ov_b) ov_cnt_b <= ov_cnt_b + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit which, input logic v, input int n);
    if (which) ser_b = v;
    else       ser_a = v;
    repeat (n) tick();
  endtask

  task automatic send_bits(input bit which, input logic [7:0] d);
    int n;
    n = which ? 16 : 1;
    drive(which, 1'b0, n);
    for (int i = 0; i < 8; i++) drive(which, d[i], n);
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input logic stopb);
    send_bits(which, d);
    drive(which, stopb, which ? 16 : 1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stopb;
    logic       exp_val;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int t0, base, f0, o0;

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0};
    tbl[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    tbl[4] = '{8'h55, 1'b0, 1'b0, 8'hFF, 1'b1};  // bad stop: byte dropped, old data kept
    tbl[5] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_data",  data_a, 8'h00);
    chk("rst_valid", val_a,  1'b0);
    chk("rst_ferr",  fe_a,   1'b0);
    chk("rst_ovr",   ov_a,   1'b0);
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b1, 2);
      base = qa_d.size();
      t0   = cyc;
      send_frame(0, tbl[i].d, tbl[i].stopb);
      repeat (LAT) tick();
      chk($sformatf("v%0d_valid", i), val_a,  tbl[i].exp_val);
      chk($sformatf("v%0d_data", i),  data_a, tbl[i].exp_data);
      chk($sformatf("v%0d_ferr", i),  fe_a,   tbl[i].exp_fe);
      chk($sformatf("v%0d_ovr", i),   ov_a,   1'b0);
      tick();
      chk($sformatf("v%0d_valid_next", i), val_a, 1'b0);
      chk($sformatf("v%0d_ferr_next", i),  fe_a,  1'b0);
      if (tbl[i].exp_val) begin
        chk($sformatf("v%0d_nbytes", i), qa_d.size() - base, 1);
        if (qa_d.size() > base) chk($sformatf("v%0d_latency", i), qa_c[base] - t0, 10 + LAT);
      end
      if (!tbl[i].stopb) begin
        f0   = fe_cnt_a;
        base = qa_d.size();
        drive(0, 1'b0, 12);
        chk("break_ferr",   fe_cnt_a - f0,       0);
        chk("break_nbytes", qa_d.size() - base,  0);
        chk("break_valid",  val_a,               1'b0);
      end
    end

    // Back-to-back frames with a single stop cycle between them.
    rdy_a = 1'b1;
    drive(0, 1'b1, 2);
    base = qa_d.size(); f0 = fe_cnt_a; o0 = ov_cnt_a;
    t0 = cyc;
    send_frame(0, 8'h3C, 1'b1);
    send_frame(0, 8'hC3, 1'b1);
    drive(0, 1'b1, 4 + LAT);
    chk("b2b_nbytes", qa_d.size() - base, 2);
    if (qa_d.size() >= base + 2) begin
      chk("b2b_d0",  qa_d[base],     8'h3C);
      chk("b2b_d1",  qa_d[base + 1], 8'hC3);
      chk("b2b_lat", qa_c[base] - t0, 10 + LAT);
      chk("b2b_gap", qa_c[base + 1] - qa_c[base], 10);
    end
    chk("b2b_ferr", fe_cnt_a - f0, 0);
    chk("b2b_ovr",  ov_cnt_a - o0, 0);

    // Overrun: hold the consumer off, then hand over on the completing cycle.
    rdy_a = 1'b0;
    o0 = ov_cnt_a;
    send_frame(0, 8'h11, 1'b1);
    drive(0, 1'b1, 2 + LAT);
    chk("ovr_first_valid", val_a,  1'b1);
    chk("ovr_first_data",  data_a, 8'h11);
    send_frame(0, 8'h22, 1'b1);
    drive(0, 1'b1, 2 + LAT);
    chk("ovr_pulses", ov_cnt_a - o0, 1);
    chk("ovr_data",   data_a, 8'h11);
    chk("ovr_valid",  val_a,  1'b1);
    send_bits(0, 8'h33);
    for (int k = 0; k <= LAT; k++) begin
      rdy_a = (k == LAT);
      drive(0, 1'b1, 1);
    end
    rdy_a = 1'b0;
    chk("handover_data",   data_a, 8'h33);
    chk("handover_valid",  val_a,  1'b1);
    chk("handover_ovr",    ov_cnt_a - o0, 1);
    rdy_a = 1'b1;
    tick();
    chk("drain_valid", val_a, 1'b0);

    // Short low pulse on the oversampled link is a glitch, not a start bit.
    base = qb_d.size(); f0 = fe_cnt_b; o0 = ov_cnt_b;
    drive(1, 1'b0, 4);
    drive(1, 1'b1, 30);
    chk("glitch_nbytes", qb_d.size() - base, 0);
    chk("glitch_ferr",   fe_cnt_b - f0, 0);
    chk("glitch_valid",  val_b, 1'b0);
    t0 = cyc;
    send_frame(1, 8'h96, 1'b1);
    drive(1, 1'b1, 20 + LAT);
    chk("os_nbytes", qb_d.size() - base, 1);
    if (qb_d.size() > base) begin
      chk("os_data", qb_d[base], 8'h96);
      chk("os_lat",  qb_c[base] - t0, 152 + LAT);
    end
    chk("os_ferr", fe_cnt_b - f0, 0);
    chk("os_ovr",  ov_cnt_b - o0, 0);

    // Reset in the middle of a frame while an unconsumed byte is held.
    rdy_a = 1'b0;
    drive(0, 1'b1, 2);
    send_frame(0, 8'h5A, 1'b1);
    drive(0, 1'b1, 2 + LAT);
    chk("prerst_valid", val_a,  1'b1);
    chk("prerst_data",  data_a, 8'h5A);
    drive(0, 1'b0, 1);
    for (int i = 0; i < 4; i++) drive(0, 1'b0, 1);  // 0xF0 bits 0..3
    ser_a = 1'b1;
    rst   = 1'b1;
    tick();
    chk("midrst_data",  data_a, 8'h00);
    chk("midrst_valid", val_a,  1'b0);
    chk("midrst_ferr",  fe_a,   1'b0);
    chk("midrst_ovr",   ov_a,   1'b0);
    rst   = 1'b0;
    rdy_a = 1'b1;
    base = qa_d.size(); f0 = fe_cnt_a;
    drive(0, 1'b0, 12);
    chk("postrst_ferr",   fe_cnt_a - f0, 0);
    chk("postrst_nbytes", qa_d.size() - base, 0);
    chk("postrst_valid",  val_a, 1'b0);
    drive(0, 1'b1, 2);
    send_frame(0, 8'h0F, 1'b1);
    drive(0, 1'b1, 3 + LAT);
    chk("postrst_rx_nbytes", qa_d.size() - base, 1);
    if (qa_d.size() > base) chk("postrst_rx_data", qa_d[base], 8'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_uart_rx.md
Name: audio_uart_rx

Overview:
- 8N1 serial receiver, RX only; the counterpart to the team's audio UART transmitter.
- Line format: idle high, start bit 0, data[0]..data[7] LSB first, stop bit 1.
- Runs on the baseline clock; default one bit per clock, matching the transmitter. Bit period is parameterised for other links.
- Delivers bytes to downstream audio logic over a valid/ready handshake, with framing and overrun flags.

Parameters:
- CLKS_PER_BIT, 1, clocks per serial bit, legal >= 1; HALF = (CLKS_PER_BIT-1)/2 (integer division).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_serial  in  1  serial line
- o_data  out  8  received byte
- o_valid  out  1  o_data holds an unconsumed byte
- i_ready  in  1  consumer accepts o_data this cycle when o_valid=1
- o_frame_err  out  1  one-cycle pulse: stop bit sampled 0
- o_overrun  out  1  one-cycle pulse: byte completed while previous byte unconsumed

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst is synchronous and active-high.
- Reset values: o_data=0x00, o_valid=0, o_frame_err=0, o_overrun=0, state=WAIT_IDLE, bit index=0, counter=0.
- Line sample s: i_serial directly, or the synchronized version when the optional feature is compiled in.
- States: WAIT_IDLE, IDLE, START, DATA, STOP.
- WAIT_IDLE: stay until s=1, then go to IDLE. This rejects the transmitter's post-reset low level and break conditions.
- IDLE, s=0 seen at cycle t0:
  - HALF=0: go to DATA, counter=CLKS_PER_BIT-1, bit index=0.
  - HALF>0: go to START, counter=HALF-1.
- START: decrement the counter. When counter=0, check s:
  - s=0: go to DATA, counter=CLKS_PER_BIT-1, bit index=0.
  - s=1: glitch; return to IDLE with no flags.
- DATA:
  - counter!=0: decrement.
  - counter=0: shift s into bit[index] and reload counter=CLKS_PER_BIT-1.
  - After index 7, go to STOP; otherwise index+1.
- STOP, on the sample cycle (counter=0), then:
  - s=1: byte complete; go to IDLE. A start bit on the very next cycle must be accepted (back-to-back frames).
  - s=0: pulse o_frame_err next cycle, discard the byte, go to WAIT_IDLE.
- Output register, updated the cycle after the stop sample (registered):
  - o_valid=0, or o_valid=1 with i_ready=1 in the same cycle: load o_data, o_valid=1.
  - o_valid=1 with i_ready=0: keep the old o_data, drop the new byte, pulse o_overrun.
  - Consume with no new byte: o_valid to 0 next cycle.
- Latency at CLKS_PER_BIT=1, no sync: start at t0, bits t0+1..t0+8, stop t0+9, o_valid=1 and o_data valid at t0+10.
- Reset mid-frame: abandon the frame, restore reset values, no flags; resume through WAIT_IDLE.
- Counter width: clog2(CLKS_PER_BIT)+1 bits; bit index 3 bits.

Optional Feature:
- Macro: AUDIO_UART_RX_SYNC_EN.
- Defined: i_serial passes through a two-flop synchronizer before use.
  - Synchronizer flops reset to 1.
  - All latencies grow by 2 cycles; o_valid at t0+12 for CLKS_PER_BIT=1.
- Undefined: i_serial is used directly. Legal only when the driver is on the same clock domain.

Decomposition:
- Shared package audio_uart_pkg:
  - state encoding constants WAIT_IDLE..STOP;
  - DATA_BITS=8;
  - line level constants IDLE_LEVEL=1, START_LEVEL=0.
- One sub-module: audio_uart_rx_sync, the two-flop synchronizer. It is instantiated only under AUDIO_UART_RX_SYNC_EN.

Test Plan:
- Single byte: CLKS_PER_BIT=1, line high, then send 0xA5 with start at t0 -> o_data=0xA5 and o_valid=1 at t0+10; i_ready=1 -> o_valid=0 at t0+11.
- Back-to-back: send 0x3C then 0xC3 with a single one-cycle stop bit, i_ready held 1 -> two valid bytes 0x3C, 0xC3, ten cycles apart, no flags.
- Framing: send 0x55 with stop bit 0, line low for 5 more cycles -> o_frame_err pulses once, o_valid stays 0; no start detected until the line returns high; next 0x81 received correctly.
- Overrun: receive 0x11 with i_ready=0, then receive 0x22 -> o_overrun pulses, o_data stays 0x11; an i_ready pulse on the cycle 0x33 completes -> o_data=0x33, o_valid stays 1, no overrun.
- Glitch and oversample: CLKS_PER_BIT=16, line low for 4 cycles -> no frame, no flags; then 0x96 at 16 clocks/bit -> o_data=0x96.
- Reset mid-frame: assert i_rst during bit 4 of 0xF0 -> all outputs 0 next cycle, line held low after reset ignored until high; then 0x0F received correctly.
